// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch sequencer: datapath width, reset vector and
// the 2-bit state encoding that the debug/trace logic decodes.
package fetch_ctrl_pkg;

  localparam int WORD_SIZE = 16;
  localparam logic [WORD_SIZE-1:0] RESET_VECTOR = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// PC sequencer: sequential fetch, stall hold, redirect (deferred to read completion).
// Outputs are Mealy, same cycle as inputs; mem_ready low holds the PC with the request raised.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_target,
  input  logic                 mem_ready,
  input  logic [WORD_SIZE-1:0] pc_in,
  output logic                 pcWrite,
  output logic [WORD_SIZE-1:0] nextAddr,
  output logic                 i_readM,
  output logic                 fetch_valid,
  output logic                 flush,
  output logic [WORD_SIZE-1:0] num_inst
);

  fetch_state_e         state_q, state_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [WORD_SIZE-1:0] pend_target_q, pend_target_d;
  logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    num_inst_d    = num_inst_q;
    pcWrite       = 1'b0;
    nextAddr      = RESET_VECTOR;
    i_readM       = 1'b0;
    fetch_valid   = 1'b0;
    flush         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pcWrite = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH, ST_WAIT: begin
        i_readM = 1'b1;
        flush   = redirect_valid;
        if (mem_ready) begin
          if (pend_valid_q || redirect_valid) begin
            // A live redirect is newer than anything parked, so it wins.
            pcWrite      = 1'b1;
            nextAddr     = redirect_valid ? redirect_target : pend_target_q;
            pend_valid_d = 1'b0;
            state_d      = ST_FETCH;
          end else if (stall) begin
            state_d = ST_HOLD;
          end else begin
            pcWrite     = 1'b1;
            nextAddr    = pc_in + WORD_SIZE'(1);
            fetch_valid = 1'b1;
            state_d     = ST_FETCH;
          end
        end else begin
          if (redirect_valid) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redirect_target;
          end
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        flush = redirect_valid;
        if (redirect_valid) begin
          pcWrite  = 1'b1;
          nextAddr = redirect_target;
          state_d  = ST_FETCH;
        end else if (!stall) begin
          state_d = ST_FETCH;
        end
      end
    endcase

    if (fetch_valid) begin
      num_inst_d = num_inst_q + WORD_SIZE'(1);
    end

    if (!Reset_N) begin
      pcWrite      = 1'b1;
      nextAddr     = RESET_VECTOR;
      i_readM      = 1'b0;
      fetch_valid  = 1'b0;
      flush        = 1'b0;
      state_d      = ST_IDLE;
      pend_valid_d = 1'b0;
      num_inst_d   = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      num_inst_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      num_inst_q   <= num_inst_d;
    end
  end

  // The target is only meaningful while pend_valid_q is set, so it needs no reset.
  always_ff @(posedge Clk) begin
    pend_target_q <= pend_target_d;
  end

  assign num_inst = num_inst_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the program counter register in the pipelined CPU. It owns the PC write enable and next-address value, and drives the instruction-memory read request. It enforces a defined reset vector, and arbitrates sequential fetch, hazard stalls and branch/jump redirects. A redirect that arrives while a memory read is outstanding is held until that read completes. The block sits between the PC register, instruction memory, the hazard unit and the branch-resolution logic, and feeds the IF/ID valid bit.

## Interface
- WORD_SIZE, 16, address/data width (global constant)
- RESET_VECTOR, 0, first fetch address after reset
- Clk  in  1  single clock; all state updates on posedge
- Reset_N  in  1  synchronous, active-low reset; sampled on posedge Clk only
- stall  in  1  hazard unit: hold current PC, do not deliver instruction
- redirect_valid  in  1  branch taken / jump resolved this cycle
- redirect_target  in  WORD_SIZE  target address, qualified by redirect_valid
- mem_ready  in  1  instruction memory: read data valid this cycle
- pc_in  in  WORD_SIZE  current PC register value
- pcWrite  out  1  PC load enable
- nextAddr  out  WORD_SIZE  value loaded into PC when pcWrite=1
- i_readM  out  1  instruction read request
- fetch_valid  out  1  memory data this cycle is a valid instruction for IF/ID
- flush  out  1  kill younger in-flight instructions
- num_inst  out  WORD_SIZE  count of delivered instructions

## Operation
- Registered state: FSM (IDLE, FETCH, WAIT, HOLD), pend_valid, pend_target, num_inst. All other outputs are Mealy (combinational from state and inputs).
- Reset (Reset_N=0 at posedge): state←IDLE, pend_valid←0, num_inst←0. While Reset_N=0, outputs are pcWrite=1, nextAddr=RESET_VECTOR, i_readM=0, fetch_valid=0, flush=0.
- IDLE: same outputs as reset. Always transitions to FETCH. redirect_valid is ignored.
- FETCH/WAIT: i_readM=1.
  - Completion (mem_ready=1), priority order:
    - (a) pend_valid or redirect_valid: pcWrite=1, nextAddr=redirect_target if redirect_valid else pend_target; fetch_valid=0; pend_valid←0; →FETCH.
    - (b) stall: pcWrite=0, fetch_valid=0; →HOLD.
    - (c) otherwise: pcWrite=1, nextAddr=pc_in+1 (mod 2^WORD_SIZE), fetch_valid=1; →FETCH.
  - No completion (mem_ready=0): pcWrite=0, fetch_valid=0. If redirect_valid: pend_valid←1, pend_target←redirect_target. FETCH→WAIT; WAIT stays WAIT.
- HOLD: i_readM=0, fetch_valid=0.
  - redirect_valid: pcWrite=1, nextAddr=redirect_target; →FETCH.
  - stall still high: pcWrite=0; stay.
  - stall low: pcWrite=0; →FETCH, which re-fetches the same PC.
- flush=redirect_valid in every state except IDLE/reset.
- pend_target: a newer redirect overwrites an existing pending one (newest wins).
- num_inst increments by 1 on every cycle with fetch_valid=1. It wraps from 2^WORD_SIZE−1 to 0.

## Timing
- Steady state (mem_ready always 1, no stall/redirect): one instruction per cycle. The PC advances each posedge.
- First fetch: request issued in the cycle after reset deassertion, at address RESET_VECTOR.
- Redirect in FETCH with mem_ready=1: target is in the PC at the next posedge. Zero bubbles beyond the flushed fetch.
- Redirect during WAIT: applied on the completion cycle. The completed read is discarded.
- Simultaneous stall+redirect: redirect wins.
- Simultaneous redirect_valid and pend_valid at completion: the live redirect_valid target wins.
- Reset mid-WAIT or with a pending redirect: the pending redirect is dropped and the outstanding read is abandoned. The next fetch is at RESET_VECTOR.
- PC wrap: pc_in=16'hFFFF gives nextAddr=16'h0000.

## Structure
- WORD_SIZE comes from the shared parameter header. State encoding (2-bit: IDLE=0, FETCH=1, WAIT=2, HOLD=3) is a shared constant so the debug/trace logic can decode it.
- Single module, no sub-module. The FSM, pending-redirect register and counter are inline.

## Test plan
- Reset then mem_ready=1 continuously for 5 cycles → PC sequence 0,1,2,3,4; fetch_valid=1 each completion; num_inst=5.
- mem_ready low for 3 cycles at PC=2 → state WAIT, pcWrite=0, i_readM=1; on completion PC→3 and num_inst increments once.
- redirect_valid (target 16'h0040) during WAIT at PC=5, then mem_ready → flush=1 in the redirect cycle; on completion fetch_valid=0 and PC=16'h0040.
- stall=1 for 2 cycles at PC=7 → HOLD, PC stays 7, no fetch_valid; after release PC 7 is re-fetched and delivered once.
- stall=1 and redirect_valid (target 16'h0100) in the same cycle → PC=16'h0100 next cycle, flush=1.
- Reset_N=0 while in WAIT with a pending redirect → next fetch at RESET_VECTOR; num_inst=0; the redirect is not applied.
